// File: rtl/div_detect_pkg.sv
// div_detect_pkg: FSM state type and default sizing shared by the divided-clock detector
package div_detect_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam int CNT_W_DEF  = 8;
    localparam int LOCK_N_DEF = 4;
endpackage

// File: rtl/div_detect_if.sv
// div_detect_if: divided clock in, measurement results out
interface div_detect_if
    import div_detect_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             clk_div;
    logic             meas_vld;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] low_time;
    logic             duty_ok;
    logic             locked;
    logic             timeout;
    modport master (output clk_div, input meas_vld, period, high_time, low_time, duty_ok, locked, timeout);
    modport slave  (input clk_div, output meas_vld, period, high_time, low_time, duty_ok, locked, timeout);
endinterface

// File: rtl/div_edge_sync.sv
// div_edge_sync: samples clk_div (2-flop synchronizer first when DIV_DETECT_SYNC_EN is defined) and flags its edges
module div_edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic s_q, prev_q, in_w;
`ifdef DIV_DETECT_SYNC_EN
    logic [1:0] sync_q;
    // Two-flop synchronizer for a clk_div source asynchronous to clk_in
    always_ff @(posedge clk_in) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], d_i};
    end
    assign in_w = sync_q[1];
`else
    assign in_w = d_i;
`endif
    // Current sample s and previous sample s_d of the divided clock
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            s_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s_q    <= in_w;
            prev_q <= s_q;
        end
    end
    assign rise_o = s_q & ~prev_q;
    assign fall_o = ~s_q & prev_q;
endmodule

// File: rtl/div_detect.sv
// div_detect: measures period, high/low time and duty balance of clk_div, tracks lock and stuck phases (option DIV_DETECT_SYNC_EN)
module div_detect
    import div_detect_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic        clk_in,
    input  logic        rst,
    div_detect_if.slave bus
);
    localparam int MW = $clog2(LOCK_N + 1);
    // A phase counter at this value with no edge would reach the all-ones limit next cycle
    localparam logic [CNT_W-1:0] LIM = ~CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d, high_q, high_d, low_q, low_d;
    logic [CNT_W:0]   period_q, period_d, sum_w;
    logic [MW-1:0]    match_q, match_d;
    logic             duty_q, duty_d, locked_q, locked_d, vld_q, vld_d, to_q, to_d;
    logic             rise_w, fall_w;

    div_edge_sync u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d_i    (bus.clk_div),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    assign sum_w = {1'b0, hi_q} + {1'b0, lo_q};

    // Phase FSM: count high/low lengths, publish a measurement on each rise out of LOW, bail to IDLE on a stuck phase
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        period_d = period_q;
        high_d   = high_q;
        low_d    = low_q;
        duty_d   = duty_q;
        match_d  = match_q;
        locked_d = locked_q;
        vld_d    = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_w) begin
                    state_d = HIGH;
                    hi_d    = CNT_W'(1);
                    lo_d    = '0;
                end
            end
            HIGH: begin
                if (fall_w) begin
                    state_d = LOW;
                    lo_d    = CNT_W'(1);
                end else if (hi_q == LIM) begin
                    state_d  = IDLE;
                    to_d     = 1'b1;
                    hi_d     = '0;
                    lo_d     = '0;
                    match_d  = '0;
                    locked_d = 1'b0;
                end else begin
                    hi_d = hi_q + 1'b1;
                end
            end
            LOW: begin
                if (rise_w) begin
                    state_d  = HIGH;
                    period_d = sum_w;
                    high_d   = hi_q;
                    low_d    = lo_q;
                    duty_d   = (hi_q == lo_q);
                    vld_d    = 1'b1;
                    match_d  = (sum_w != period_q) ? MW'(1) :
                               (match_q >= MW'(LOCK_N)) ? match_q : match_q + 1'b1;
                    locked_d = (match_d >= MW'(LOCK_N));
                    hi_d     = CNT_W'(1);
                    lo_d     = '0;
                end else if (lo_q == LIM) begin
                    state_d  = IDLE;
                    to_d     = 1'b1;
                    hi_d     = '0;
                    lo_d     = '0;
                    match_d  = '0;
                    locked_d = 1'b0;
                end else begin
                    lo_d = lo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            low_q    <= '0;
            duty_q   <= 1'b0;
            match_q  <= '0;
            locked_q <= 1'b0;
            vld_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            period_q <= period_d;
            high_q   <= high_d;
            low_q    <= low_d;
            duty_q   <= duty_d;
            match_q  <= match_d;
            locked_q <= locked_d;
            vld_q    <= vld_d;
            to_q     <= to_d;
        end
    end

    assign bus.meas_vld  = vld_q;
    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.low_time  = low_q;
    assign bus.duty_ok   = duty_q;
    assign bus.locked    = locked_q;
    assign bus.timeout   = to_q;
endmodule

// File: doc/div_detect.md
DIV_DETECT -- requirements
Module: div_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the high-time and low-time counters.
REQ-002 SHALL have parameter LOCK_N, default 4, giving the number of consecutive equal periods required for lock.
REQ-003 SHALL have port clk_in, input, 1 bit: the measurement clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port clk_div, input, 1 bit: the divided clock under measurement, sampled as data.
REQ-006 SHALL have port meas_vld, output, 1 bit: one-cycle pulse marking a completed clk_div period.
REQ-007 SHALL have port period, output, CNT_W+1 bits: the last period in clk_in cycles, held between pulses.
REQ-008 SHALL have port high_time, output, CNT_W bits: the high-phase length of the last period.
REQ-009 SHALL have port low_time, output, CNT_W bits: the low-phase length of the last period.
REQ-010 SHALL have port duty_ok, output, 1 bit: high_time equals low_time for the last period.
REQ-011 SHALL have port locked, output, 1 bit: the period has been stable for LOCK_N consecutive measurements.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse on a stuck or overlong phase.

Function
REQ-013 SHALL register clk_div as sample s and keep the previous sample s_d; a rise is s=1 and s_d=0.
REQ-014 SHALL implement the FSM IDLE -> HIGH -> LOW -> HIGH...; IDLE leaves only on a rise.
REQ-015 In HIGH, hi_cnt SHALL increment each cycle that s=1; the cycle that detects the rise loads hi_cnt=1 and lo_cnt=0.
REQ-016 SHALL go from HIGH to LOW on the first cycle with s=0, loading lo_cnt=1; in LOW, lo_cnt SHALL increment each cycle that s=0.
REQ-017 On a rise in LOW, SHALL register period=hi_cnt+lo_cnt (zero-extended to CNT_W+1), high_time=hi_cnt, low_time=lo_cnt and duty_ok, pulse meas_vld the next cycle, and restart HIGH.
REQ-018 The first rise after IDLE SHALL NOT produce meas_vld, because that period is incomplete.
REQ-019 Each meas_vld SHALL update the match count: if period equals the previous valid period, increment saturating at LOCK_N; otherwise set it to 1.
REQ-020 locked SHALL be 1 exactly when the match count is at least LOCK_N, updated in the same cycle as meas_vld.
REQ-021 If hi_cnt or lo_cnt reaches 2^CNT_W-1 without a phase change, SHALL pulse timeout for one cycle, clear the match count and locked, and enter IDLE.
REQ-022 period, high_time, low_time and duty_ok SHALL hold their last values across timeout; only locked clears.
REQ-023 Latency SHALL be fixed: meas_vld is asserted 2 clk_in cycles after the rising clk_div level is presented at the input (no-sync build).

Reset
REQ-024 When rst=0 at a clk_in edge, SHALL put the FSM in IDLE and clear all counters, the match count and the sync flops.
REQ-025 During reset, all outputs SHALL be 0.
REQ-026 Reset mid-measurement SHALL discard the partial period, and no meas_vld SHALL follow it.

Configuration
REQ-027 With macro DIV_DETECT_SYNC_EN defined, SHALL insert a 2-flop synchronizer ahead of s, adding exactly 2 cycles to all latencies (meas_vld latency becomes 4).
REQ-028 Without DIV_DETECT_SYNC_EN, SHALL sample clk_div directly into s, for synchronous sources only.

Structure
REQ-029 SHALL use package div_detect_pkg holding the FSM state typedef (IDLE, HIGH, LOW) and the default constants for CNT_W and LOCK_N.
REQ-030 SHALL use sub-module div_edge_sync for the optional synchronizer, the s/s_d registers and rise/fall detection; measurement and lock logic stay in div_detect.

Verification
REQ-031 clk_div toggles every clk_in cycle (divide-by-2) -> period=2, high_time=1, low_time=1, duty_ok=1; locked rises with the 4th meas_vld.
REQ-032 Divide-by-8 (4 high, 4 low) -> period=8, high_time=4, duty_ok=1; meas_vld every 8 cycles after the first full period.
REQ-033 Pattern of 3 high, 1 low -> period=4, high_time=3, low_time=1, duty_ok=0; locked still asserts after 4 valids.
REQ-034 Switch from /4 to /8 while locked -> the first /8 meas_vld drops locked; locked reasserts on the 4th consecutive /8 valid.
REQ-035 Hold clk_div high for 300 cycles with CNT_W=8 -> a single timeout pulse when hi_cnt=255, locked=0, FSM in IDLE, period unchanged.
REQ-036 Assert rst for 1 cycle mid-LOW phase -> all outputs 0; the next meas_vld appears only after two further rises.
